// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, bubble encoding, PC select codes and the
// hazard controller state type. Pipeline registers import the same package.
package cpu_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2b;
    localparam logic [5:0] OP_BUBBLE = 6'h3f;

    localparam logic [31:0] BUBBLE_INST = 32'hff000000;

    localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_ERROR    = 2'b10
    } hz_state_t;

    function automatic logic [5:0] inst_opcode(input logic [31:0] inst);
        return inst[31:26];
    endfunction

    function automatic logic [4:0] inst_rs(input logic [31:0] inst);
        return inst[25:21];
    endfunction

    function automatic logic [4:0] inst_rt(input logic [31:0] inst);
        return inst[20:16];
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the hazard controller and the pipeline: stage instructions
// and status in, stall/flush/select controls and statistics out.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      ifid_inst;
    logic [31:0]      idex_inst;
    logic [31:0]      exmem_inst;
    logic             exmem_zero;
    logic             mem_ready;
    logic             pc_enable;
    logic [1:0]       pc_src;
    logic             ifid_enable;
    logic             ifid_nop;
    logic             idex_nop;
    logic             exmem_nop;
    logic             pipe_hold;
    logic             mem_error;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output ifid_inst, idex_inst, exmem_inst, exmem_zero, mem_ready,
        input  pc_enable, pc_src, ifid_enable, ifid_nop, idex_nop, exmem_nop,
        input  pipe_hold, mem_error, stall_cnt, flush_cnt
    );

    modport slave (
        input  ifid_inst, idex_inst, exmem_inst, exmem_zero, mem_ready,
        output pc_enable, pc_src, ifid_enable, ifid_nop, idex_nop, exmem_nop,
        output pipe_hold, mem_error, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_decode.sv
// Per-stage instruction classifier feeding the hazard controller.
// A bubble (opcode 3f) classifies as nothing and reads no register.
module hazard_decode
    import cpu_pkg::*;
(
    input  logic [31:0] i_inst,
    output logic        o_is_load,
    output logic        o_is_mem,
    output logic        o_is_branch_eq,
    output logic        o_is_branch_ne,
    output logic        o_is_jump,
    output logic        o_reads_rs,
    output logic        o_reads_rt,
    output logic [4:0]  o_rt
);

    logic [5:0] w_op;

    assign w_op = inst_opcode(i_inst);

    // Opcode classification
    always_comb begin
        o_is_load      = 1'b0;
        o_is_mem       = 1'b0;
        o_is_branch_eq = 1'b0;
        o_is_branch_ne = 1'b0;
        o_is_jump      = 1'b0;
        o_reads_rs     = 1'b1;
        o_reads_rt     = 1'b0;
        case (w_op)
            OP_RTYPE: begin
                o_reads_rt = 1'b1;
            end
            OP_LW: begin
                o_is_load = 1'b1;
                o_is_mem  = 1'b1;
            end
            OP_SW: begin
                o_is_mem   = 1'b1;
                o_reads_rt = 1'b1;
            end
            OP_BEQ: begin
                o_is_branch_eq = 1'b1;
                o_reads_rt     = 1'b1;
            end
            OP_BNE: begin
                o_is_branch_ne = 1'b1;
                o_reads_rt     = 1'b1;
            end
            OP_J, OP_JAL: begin
                o_is_jump  = 1'b1;
                o_reads_rs = 1'b0;
            end
            OP_BUBBLE: begin
                o_reads_rs = 1'b0;
            end
            default: begin
                o_reads_rs = 1'b1;
            end
        endcase
    end

    assign o_rt = inst_rt(i_inst);

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline: memory-wait freeze with
// timeout, branch flush, load-use stall, jump flush, plus saturating statistics.
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  bus
);

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    hz_state_t        r_state;
    logic [7:0]       r_wait_cnt;
    logic             r_mem_error;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_id_load, w_id_mem, w_id_beq, w_id_bne, w_id_jump, w_id_rs, w_id_rt;
    logic w_ex_load, w_ex_mem, w_ex_beq, w_ex_bne, w_ex_jump, w_ex_rs, w_ex_rt;
    logic w_mm_load, w_mm_mem, w_mm_beq, w_mm_bne, w_mm_jump, w_mm_rs, w_mm_rt;
    logic [4:0] w_id_rt_idx, w_ex_rt_idx, w_mm_rt_idx;
    logic [4:0] w_id_rs_idx;

    logic       w_mem_wait;
    logic       w_branch;
    logic       w_load_use;
    logic       w_jump;
    logic       w_pc_enable;
    logic [1:0] w_pc_src;
    logic       w_ifid_enable;
    logic       w_ifid_nop;
    logic       w_idex_nop;
    logic       w_exmem_nop;
    logic       w_pipe_hold;
    logic       w_flush_act;

    hazard_decode u_dec_id (
        .i_inst         (bus.ifid_inst),
        .o_is_load      (w_id_load),
        .o_is_mem       (w_id_mem),
        .o_is_branch_eq (w_id_beq),
        .o_is_branch_ne (w_id_bne),
        .o_is_jump      (w_id_jump),
        .o_reads_rs     (w_id_rs),
        .o_reads_rt     (w_id_rt),
        .o_rt           (w_id_rt_idx)
    );

    hazard_decode u_dec_ex (
        .i_inst         (bus.idex_inst),
        .o_is_load      (w_ex_load),
        .o_is_mem       (w_ex_mem),
        .o_is_branch_eq (w_ex_beq),
        .o_is_branch_ne (w_ex_bne),
        .o_is_jump      (w_ex_jump),
        .o_reads_rs     (w_ex_rs),
        .o_reads_rt     (w_ex_rt),
        .o_rt           (w_ex_rt_idx)
    );

    hazard_decode u_dec_mem (
        .i_inst         (bus.exmem_inst),
        .o_is_load      (w_mm_load),
        .o_is_mem       (w_mm_mem),
        .o_is_branch_eq (w_mm_beq),
        .o_is_branch_ne (w_mm_bne),
        .o_is_jump      (w_mm_jump),
        .o_reads_rs     (w_mm_rs),
        .o_reads_rt     (w_mm_rt),
        .o_rt           (w_mm_rt_idx)
    );

    assign w_id_rs_idx = inst_rs(bus.ifid_inst);

    assign w_mem_wait = w_mm_mem & ~bus.mem_ready;
    assign w_branch   = (w_mm_beq & bus.exmem_zero) | (w_mm_bne & ~bus.exmem_zero);
    assign w_load_use = w_ex_load && (w_ex_rt_idx != 5'd0) &&
                        ((w_id_rs && (w_id_rs_idx == w_ex_rt_idx)) ||
                         (w_id_rt && (w_id_rt_idx == w_ex_rt_idx)));
    assign w_jump     = w_id_jump;

    // Control outputs: reset bubbles first, then freeze, then hazards by priority
    always_comb begin
        w_pc_enable   = 1'b1;
        w_pc_src      = PC_SRC_SEQ;
        w_ifid_enable = 1'b1;
        w_ifid_nop    = 1'b0;
        w_idex_nop    = 1'b0;
        w_exmem_nop   = 1'b0;
        w_pipe_hold   = 1'b0;
        w_flush_act   = 1'b0;
        if (rst) begin
            w_pc_enable   = 1'b0;
            w_ifid_enable = 1'b0;
            w_ifid_nop    = 1'b1;
            w_idex_nop    = 1'b1;
            w_exmem_nop   = 1'b1;
        end else if ((r_state == ST_ERROR) || w_mem_wait) begin
            w_pc_enable   = 1'b0;
            w_ifid_enable = 1'b0;
            w_pipe_hold   = 1'b1;
        end else if (w_branch) begin
            w_pc_src    = PC_SRC_BRANCH;
            w_ifid_nop  = 1'b1;
            w_idex_nop  = 1'b1;
            w_exmem_nop = 1'b1;
            w_flush_act = 1'b1;
        end else if (w_load_use) begin
            w_pc_enable   = 1'b0;
            w_ifid_enable = 1'b0;
            w_idex_nop    = 1'b1;
        end else if (w_jump) begin
            w_pc_src    = PC_SRC_JUMP;
            w_ifid_nop  = 1'b1;
            w_flush_act = 1'b1;
        end else begin
            w_pc_enable = 1'b1;
        end
    end

    // Memory-wait FSM with timeout counter and sticky error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_wait_cnt  <= 8'd0;
            r_mem_error <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_mem_wait) begin
                        r_state    <= ST_MEM_WAIT;
                        r_wait_cnt <= 8'd0;
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                ST_MEM_WAIT: begin
                    if (!w_mem_wait) begin
                        r_state <= ST_RUN;
                    end else if (r_wait_cnt == WAIT_LAST) begin
                        r_state     <= ST_ERROR;
                        r_mem_error <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                ST_ERROR: begin
                    r_state     <= ST_ERROR;
                    r_mem_error <= 1'b1;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    // Saturating stall and flush statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= {CNT_W{1'b0}};
            r_flush_cnt <= {CNT_W{1'b0}};
        end else begin
            if (!w_pc_enable && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
            if (w_flush_act && (r_flush_cnt != {CNT_W{1'b1}})) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end else begin
                r_flush_cnt <= r_flush_cnt;
            end
        end
    end

    assign bus.pc_enable   = w_pc_enable;
    assign bus.pc_src      = w_pc_src;
    assign bus.ifid_enable = w_ifid_enable;
    assign bus.ifid_nop    = w_ifid_nop;
    assign bus.idex_nop    = w_idex_nop;
    assign bus.exmem_nop   = w_exmem_nop;
    assign bus.pipe_hold   = w_pipe_hold;
    assign bus.mem_error   = r_mem_error;
    assign bus.stall_cnt   = r_stall_cnt;
    assign bus.flush_cnt   = r_flush_cnt;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the five-stage CPU. It watches the instructions held in the IF/ID, ID/EX and EX/MEM pipeline registers, plus the data-memory ready line. It drives the enable, NOP (bubble) and hold inputs of those registers, and it drives the PC select. It is the producer of every stall and flush that the pipeline registers consume, and it also keeps saturating stall and flush statistics.

## Interface
Parameters:
- MEM_TIMEOUT, default 16: number of MEM_WAIT cycles allowed before the block declares a memory error (range 2 to 255).
- CNT_W, default 16: width of the statistics counters.

Ports:
- clk  in  1  rising-edge clock shared with all pipeline registers.
- rst  in  1  synchronous, active-high reset.
- ifid_inst  in  32  instruction currently in IF/ID (ID stage).
- idex_inst  in  32  instruction currently in ID/EX (EX stage).
- exmem_inst  in  32  instruction currently in EX/MEM (MEM stage).
- exmem_zero  in  1  ALU Zero flag latched in EX/MEM.
- mem_ready  in  1  data memory has completed the current access.
- pc_enable  out  1  PC register load enable.
- pc_src  out  2  00 = PC+4, 01 = branch target (EX/MEM adder result), 10 = jump target.
- ifid_enable  out  1  IF/ID load enable.
- ifid_nop  out  1  load the bubble into IF/ID.
- idex_nop  out  1  load the bubble into ID/EX.
- exmem_nop  out  1  load the bubble into EX/MEM.
- pipe_hold  out  1  hold ID/EX, EX/MEM and MEM/WB at their current contents.
- mem_error  out  1  sticky memory-timeout flag.
- stall_cnt  out  CNT_W  number of cycles with pc_enable=0.
- flush_cnt  out  CNT_W  number of taken branches plus jumps.

## Operation
- Bubble encoding is 32'hff000000 (opcode 6'h3f). A bubble never triggers any hazard.
- Field layout:
  - opcode = [31:26], rs = [25:21], rt = [20:16].
  - lw = 6'h23, sw = 6'h2b, beq = 6'h04, bne = 6'h05, j = 6'h02, jal = 6'h03, R-type = 6'h00.
- Sources read by the ID instruction:
  - rs is read by every opcode except j, jal and bubble.
  - rt is read by R-type, sw, beq and bne.
- The FSM has three states: RUN, MEM_WAIT, ERROR. Reset enters RUN.
- Memory wait condition: exmem_inst is lw or sw and mem_ready=0.
  - In RUN, this freezes the pipeline in the same cycle and moves the FSM to MEM_WAIT.
  - In MEM_WAIT, the pipeline stays frozen.
  - When mem_ready=1 the FSM returns to RUN; that cycle is not frozen.
- Freeze means: pc_enable=0, ifid_enable=0, pipe_hold=1, all *_nop=0, pc_src=00.
- MEM_WAIT timeout:
  - An 8-bit wait counter is cleared on entry to MEM_WAIT and increments in each MEM_WAIT cycle.
  - If the counter equals MEM_TIMEOUT-1 and mem_ready=0, the FSM moves to ERROR.
- ERROR: the pipeline is frozen permanently and mem_error=1. Only rst leaves ERROR.
- Conditions evaluated in RUN, in priority order; only the highest-priority true condition acts:
  1. Memory wait (above).
  2. Branch taken: exmem_inst is beq with exmem_zero=1, or bne with exmem_zero=0. Outputs: pc_src=01, ifid_nop=1, idex_nop=1, exmem_nop=1.
  3. Load-use: idex_inst is lw, its rt is not 0, and ifid_inst reads a source equal to that rt. Outputs: pc_enable=0, ifid_enable=0, idex_nop=1.
  4. Jump: ifid_inst is j or jal. Outputs: pc_src=10, ifid_nop=1.
  5. Otherwise: pc_enable=1, ifid_enable=1, all NOP and hold outputs 0, pc_src=00.
- Counters:
  - stall_cnt increments in every cycle with pc_enable=0.
  - flush_cnt increments in every cycle where a taken branch or a jump acts.
  - Both saturate at all-ones.

## Timing
- All control outputs are combinational from the FSM state and the current inputs. They are valid before the rising edge at which the pipeline registers sample them.
- Registered state is: the FSM state, the wait counter, mem_error, stall_cnt and flush_cnt.
- Reset values: FSM=RUN, wait counter=0, mem_error=0, stall_cnt=0, flush_cnt=0.
- While rst=1, the outputs are forced to pc_enable=0, ifid_enable=0, ifid_nop=1, idex_nop=1, exmem_nop=1, pipe_hold=0, pc_src=00. This loads bubbles into the pipeline.
- Load-use stall lasts exactly 1 cycle: the lw advances past ID/EX, so the condition clears by construction.
- Branch flush lasts 1 cycle. Jump flush lasts 1 cycle.
- Counter update for a stall or flush cycle is visible on the next edge.
- Branch and load-use true in the same cycle: the branch wins. The stalled ID instruction is flushed and is not stalled.
- rst asserted in MEM_WAIT or ERROR: the next state is RUN and all counters clear.

## Structure
- Shared package cpu_pkg holds:
  - the opcode constants;
  - the bubble constant 32'hff000000;
  - the pc_src encodings;
  - the FSM state enum.
  The pipeline registers use the same package.
- One sub-module, hazard_decode, is combinational. From one instruction it produces: is_load, is_mem, is_branch_eq, is_branch_ne, is_jump, reads_rs, reads_rt, rt.
- hazard_ctrl instantiates hazard_decode three times, once per stage.

## Test plan
- Load-use: idex_inst = lw rt=5; ifid_inst = R-type with rs=5.
  - Required: exactly 1 cycle of pc_enable=0, ifid_enable=0, idex_nop=1.
  - Required: stall_cnt goes 0 to 1.
  - Repeat with rt=0: no stall.
- beq taken: exmem_inst = beq with exmem_zero=1.
  - Required: pc_src=01 and all three NOPs = 1 for 1 cycle; flush_cnt=1.
  - bne with exmem_zero=1: no flush.
- Branch plus load-use in the same cycle:
  - Required: branch outputs only; pc_enable=1; stall_cnt unchanged.
- Memory wait: exmem_inst = sw, mem_ready=0 for 3 cycles, then 1.
  - Required: pipe_hold=1 for 3 cycles; RUN on the 4th cycle; stall_cnt=3.
- Timeout: MEM_TIMEOUT=4, mem_ready held at 0.
  - Required: ERROR state and mem_error=1 after the 4th MEM_WAIT cycle; freeze persists.
  - Then assert rst for 1 cycle. Required: RUN, mem_error=0, counters = 0.
- Jump: ifid_inst = j.
  - Required: pc_src=10 and ifid_nop=1 for 1 cycle.
  - A bubble in any stage never triggers any condition.
